// File: rtl/mini_core_pkg.sv
// mini_core_pkg: shared memory-stage types, encodings and the enable-DFF macro.
`ifndef MINI_CORE_DFF_EN
`define MINI_CORE_DFF_EN(q, d, en, clk, rst_n) \
    always_ff @(posedge clk or negedge rst_n) \
        if (!rst_n) q <= '0; \
        else if (en) q <= d;
`endif

package mini_core_pkg;

    localparam logic [1:0] LS_B = 2'd0;
    localparam logic [1:0] LS_H = 2'd1;
    localparam logic [1:0] LS_W = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic {S_IDLE, S_WAIT_RSP} t_mem_state;

    typedef struct packed {
        logic       dmem_rd_en;
        logic       dmem_wr_en;
        logic [1:0] ls_size;
        logic       ld_sign_ext;
        logic [1:0] sel_wb;
        logic       reg_wr_en;
        logic [4:0] reg_dst;
    } t_ctrl_mem;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == LS_H && a[0]) || (size == LS_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/mini_core_mem_align.sv
// mini_core_mem_align: store byte-lane steering and load extraction/extension.
module mini_core_mem_align
    import mini_core_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr,
    input  logic [31:0] st_raw,
    input  logic [31:0] rsp_data,
    output logic [3:0]  byte_en,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);
    logic [31:0] sh;

    assign sh      = rsp_data >> {addr, 3'b000};
    assign byte_en = size == LS_B ? 4'b0001 << addr
                   : size == LS_H ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    assign st_data = size == LS_B ? {4{st_raw[7:0]}}
                   : size == LS_H ? {2{st_raw[15:0]}} : st_raw;
    assign ld_data = size == LS_B ? {{24{sign_ext & sh[7]}}, sh[7:0]}
                   : size == LS_H ? {{16{sign_ext & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mini_core_mem.sv
// mini_core_mem: Q103H memory stage with request/response handshake, load timeout,
// misalignment trap and Q104H write-back registers.
module mini_core_mem
    import mini_core_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  t_ctrl_mem   ctrl,
    input  logic [31:0] alu_out_q103h,
    input  logic [31:0] dmem_wr_data_q103h,
    input  logic [31:0] pc_plus4_q103h,
    output logic        ready_q103h,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_wr_en,
    output logic [3:0]  dmem_req_byte_en,
    output logic [31:0] dmem_req_wr_data,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic [31:0] reg_wr_data_q104h,
    output logic [4:0]  reg_dst_q104h,
    output logic        reg_wr_en_q104h,
    output logic        misalign_q104h,
    output logic        timeout_q104h
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;

    t_mem_state    state;
    logic [CW-1:0] cnt;
    logic          mem_op, mis, req_ok, waiting, rsp_hit, timeout_hit;
    logic [31:0]   ld_data, wb_data;

    assign mem_op      = ctrl.dmem_rd_en | ctrl.dmem_wr_en;
    assign mis         = mem_op & misaligned(ctrl.ls_size, alu_out_q103h[1:0]);
    assign req_ok      = state == S_IDLE && mem_op && !mis;
    assign waiting     = state == S_WAIT_RSP;
    assign rsp_hit     = waiting && dmem_rsp_valid;
    // A response arriving in the timeout cycle still wins over the timeout.
    assign timeout_hit = waiting && !dmem_rsp_valid && cnt == CW'(TIMEOUT_CYC);

    assign dmem_req_valid = req_ok & rst_n;
    assign dmem_req_addr  = {alu_out_q103h[31:2], 2'b00};
    assign dmem_req_wr_en = ctrl.dmem_wr_en;

    assign ready_q103h = waiting ? rsp_hit | timeout_hit
                       : req_ok ? ctrl.dmem_wr_en & dmem_req_ready : 1'b1;

    mini_core_mem_align u_align (
        .size     (ctrl.ls_size),
        .sign_ext (ctrl.ld_sign_ext),
        .addr     (alu_out_q103h[1:0]),
        .st_raw   (dmem_wr_data_q103h),
        .rsp_data (dmem_rsp_data),
        .byte_en  (dmem_req_byte_en),
        .st_data  (dmem_req_wr_data),
        .ld_data  (ld_data)
    );

    assign wb_data = ctrl.sel_wb == WB_MEM ? (timeout_hit ? 32'h0 : ld_data)
                   : ctrl.sel_wb == WB_PC4 ? pc_plus4_q103h
                   : ctrl.sel_wb == WB_ALU ? alu_out_q103h : alu_out_q103h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= waiting ? (ready_q103h ? S_IDLE : S_WAIT_RSP)
                   : (req_ok && !ctrl.dmem_wr_en && dmem_req_ready ? S_WAIT_RSP : S_IDLE);
            cnt   <= waiting ? cnt + 1'b1 : '0;
        end
    end

    `MINI_CORE_DFF_EN(reg_wr_data_q104h, wb_data, ready_q103h, clk, rst_n)
    `MINI_CORE_DFF_EN(reg_dst_q104h, ctrl.reg_dst, ready_q103h, clk, rst_n)
    `MINI_CORE_DFF_EN(reg_wr_en_q104h, ctrl.reg_wr_en & ~mis, ready_q103h, clk, rst_n)
    `MINI_CORE_DFF_EN(misalign_q104h, mis, ready_q103h, clk, rst_n)
    `MINI_CORE_DFF_EN(timeout_q104h, timeout_hit, ready_q103h, clk, rst_n)
endmodule

// File: tb/tb_mini_core_mem.sv
// tb_mini_core_mem: directed vector table plus hand sequences for stall, timeout and reset.
module tb_mini_core_mem;
    import mini_core_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    t_ctrl_mem   ctrl;
    logic [31:0] alu, wd, pc4, rsp_data;
    logic        req_ready, rsp_valid;
    logic        ready, req_valid, req_wr_en, we104, mis104, to104;
    logic [31:0] req_addr, req_wd, wb104;
    logic [3:0]  be;
    logic [4:0]  dst104;
    int          n_vec = 0, n_bad = 0;

    typedef struct {
        t_ctrl_mem   c;
        logic [31:0] a, wd, rsp;
        logic        ev;
        logic [3:0]  be;
        logic [31:0] ewd, wb;
        logic        we, mis;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    mini_core_mem #(.TIMEOUT_CYC(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl               (ctrl),
        .alu_out_q103h      (alu),
        .dmem_wr_data_q103h (wd),
        .pc_plus4_q103h     (pc4),
        .ready_q103h        (ready),
        .dmem_req_valid     (req_valid),
        .dmem_req_ready     (req_ready),
        .dmem_req_addr      (req_addr),
        .dmem_req_wr_en     (req_wr_en),
        .dmem_req_byte_en   (be),
        .dmem_req_wr_data   (req_wd),
        .dmem_rsp_valid     (rsp_valid),
        .dmem_rsp_data      (rsp_data),
        .reg_wr_data_q104h  (wb104),
        .reg_dst_q104h      (dst104),
        .reg_wr_en_q104h    (we104),
        .misalign_q104h     (mis104),
        .timeout_q104h      (to104)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic t_ctrl_mem mk(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic sx, input logic [1:0] sel, input logic we,
                                     input logic [4:0] dst);
        return '{dmem_rd_en: rd, dmem_wr_en: wr, ls_size: sz, ld_sign_ext: sx,
                 sel_wb: sel, reg_wr_en: we, reg_dst: dst};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctrl = '0; alu = '0; wd = '0; pc4 = 32'h200; rsp_data = '0;
        req_ready = 1'b0; rsp_valid = 1'b0;

        //            c                                          addr          wd            rsp           ev be     ewd           wb            we mis
        tv.push_back('{mk(0,0,LS_W,0,WB_ALU,1,5'd3),  32'h12345678, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h12345678, 1, 0});
        tv.push_back('{mk(0,0,LS_W,0,WB_PC4,1,5'd4),  32'h0,        32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h00000200, 1, 0});
        tv.push_back('{mk(0,0,LS_W,0,2'd3,1,5'd5),    32'hCAFEF00D, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'hCAFEF00D, 1, 0});
        tv.push_back('{mk(0,1,LS_W,0,WB_ALU,0,5'd0),  32'h104,      32'hDEADBEEF, 32'h0,        1, 4'hF, 32'hDEADBEEF, 32'h104,      0, 0});
        tv.push_back('{mk(0,1,LS_H,0,WB_ALU,0,5'd0),  32'h102,      32'h0000ABCD, 32'h0,        1, 4'hC, 32'hABCDABCD, 32'h102,      0, 0});
        tv.push_back('{mk(0,1,LS_H,0,WB_ALU,0,5'd0),  32'h100,      32'h1234ABCD, 32'h0,        1, 4'h3, 32'hABCDABCD, 32'h100,      0, 0});
        tv.push_back('{mk(0,1,LS_B,0,WB_ALU,0,5'd0),  32'h101,      32'h12345699, 32'h0,        1, 4'h2, 32'h99999999, 32'h101,      0, 0});
        tv.push_back('{mk(1,0,LS_B,1,WB_MEM,1,5'd6),  32'h103,      32'h0,        32'h80FFFFFF, 1, 4'h8, 32'h0,        32'hFFFFFF80, 1, 0});
        tv.push_back('{mk(1,0,LS_B,0,WB_MEM,1,5'd7),  32'h103,      32'h0,        32'h80FFFFFF, 1, 4'h8, 32'h0,        32'h00000080, 1, 0});
        tv.push_back('{mk(1,0,LS_H,1,WB_MEM,1,5'd8),  32'h102,      32'h0,        32'h80011234, 1, 4'hC, 32'h0,        32'hFFFF8001, 1, 0});
        tv.push_back('{mk(1,0,LS_H,0,WB_MEM,1,5'd9),  32'h100,      32'h0,        32'h8001F234, 1, 4'h3, 32'h0,        32'h0000F234, 1, 0});
        tv.push_back('{mk(1,0,LS_W,0,WB_MEM,1,5'd10), 32'h108,      32'h0,        32'h13579BDF, 1, 4'hF, 32'h0,        32'h13579BDF, 1, 0});
        tv.push_back('{mk(1,0,LS_B,1,WB_MEM,1,5'd11), 32'h101,      32'h0,        32'h00007F00, 1, 4'h2, 32'h0,        32'h0000007F, 1, 0});
        tv.push_back('{mk(1,0,LS_W,0,WB_MEM,1,5'd12), 32'h101,      32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});
        tv.push_back('{mk(1,0,LS_H,1,WB_MEM,1,5'd13), 32'h103,      32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});
        tv.push_back('{mk(0,1,LS_W,0,WB_ALU,0,5'd14), 32'h102,      32'h11223344, 32'h0,        0, 4'h0, 32'h0,        32'h0,        0, 1});

        // reset state
        #12;
        chk("rst valid", req_valid, 0);
        chk("rst wb", wb104, 0);
        chk("rst we", we104, 0);
        chk("rst dst", dst104, 0);
        chk("rst mis", mis104, 0);
        chk("rst to", to104, 0);
        cyc();
        rst_n = 1'b1;

        foreach (tv[i]) begin
            logic is_ld;
            cyc();
            ctrl = tv[i].c; alu = tv[i].a; wd = tv[i].wd; rsp_data = tv[i].rsp;
            req_ready = 1'b1; rsp_valid = 1'b0;
            #4;
            is_ld = tv[i].ev && !tv[i].c.dmem_wr_en;
            chk($sformatf("v%0d valid", i), req_valid, tv[i].ev);
            chk($sformatf("v%0d ready", i), ready, !is_ld);
            if (tv[i].ev) begin
                chk($sformatf("v%0d addr", i), req_addr, {tv[i].a[31:2], 2'b00});
                chk($sformatf("v%0d be", i), be, tv[i].be);
                chk($sformatf("v%0d wren", i), req_wr_en, tv[i].c.dmem_wr_en);
                if (!is_ld) chk($sformatf("v%0d wdata", i), req_wd, tv[i].ewd);
            end
            if (is_ld) begin
                cyc();
                req_ready = 1'b0; rsp_valid = 1'b1;
                #4;
                chk($sformatf("v%0d rsp ready", i), ready, 1);
                chk($sformatf("v%0d rsp valid", i), req_valid, 0);
            end
            cyc();
            ctrl = '0; rsp_valid = 1'b0; req_ready = 1'b0;
            if (!tv[i].mis) chk($sformatf("v%0d wb", i), wb104, tv[i].wb);
            chk($sformatf("v%0d we", i), we104, tv[i].we);
            chk($sformatf("v%0d mis", i), mis104, tv[i].mis);
            chk($sformatf("v%0d to", i), to104, 0);
            chk($sformatf("v%0d dst", i), dst104, tv[i].c.reg_dst);
        end

        // SW held until ready arrives in its third cycle; Q104H holds meanwhile
        cyc();
        ctrl = mk(0,0,LS_W,0,WB_ALU,1,5'd9); alu = 32'h55AA;
        cyc();
        ctrl = mk(0,1,LS_W,0,WB_ALU,0,5'd0); alu = 32'h104; wd = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cyc();
            req_ready = (k == 2);
            #4;
            chk($sformatf("sw c%0d valid", k), req_valid, 1);
            chk($sformatf("sw c%0d be", k), be, 4'hF);
            chk($sformatf("sw c%0d addr", k), req_addr, 32'h104);
            chk($sformatf("sw c%0d wdata", k), req_wd, 32'hDEADBEEF);
            chk($sformatf("sw c%0d ready", k), ready, k == 2);
            if (k < 2) chk($sformatf("sw c%0d hold", k), wb104, 32'h55AA);
        end
        cyc();
        ctrl = '0; req_ready = 1'b0;
        chk("sw wb", wb104, 32'h104);
        chk("sw we", we104, 0);

        // LB signed with response three wait cycles after acceptance
        cyc();
        ctrl = mk(1,0,LS_B,1,WB_MEM,1,5'd12); alu = 32'h103; req_ready = 1'b1;
        #4;
        chk("lbd valid", req_valid, 1);
        chk("lbd ready", ready, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_ready = 1'b0; rsp_valid = (k == 3); rsp_data = 32'h80FFFFFF;
            #4;
            chk($sformatf("lbd w%0d ready", k), ready, k == 3);
            chk($sformatf("lbd w%0d valid", k), req_valid, 0);
        end
        cyc();
        ctrl = '0; rsp_valid = 1'b0;
        chk("lbd wb", wb104, 32'hFFFFFF80);
        chk("lbd we", we104, 1);
        chk("lbd dst", dst104, 12);

        // load timeout: no response ever
        cyc();
        ctrl = mk(1,0,LS_W,0,WB_MEM,1,5'd20); alu = 32'h100; req_ready = 1'b1;
        rsp_data = 32'hFFFFFFFF;
        #4;
        chk("to acc ready", ready, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            req_ready = 1'b0;
            #4;
            chk($sformatf("to w%0d ready", k), ready, k == 4);
        end
        cyc();
        ctrl = '0;
        chk("to flag", to104, 1);
        chk("to wb", wb104, 0);
        chk("to we", we104, 1);
        chk("to dst", dst104, 20);
        cyc();
        chk("to clear", to104, 0);

        // reset during WAIT_RSP, late response ignored
        cyc();
        ctrl = mk(0,0,LS_W,0,WB_ALU,1,5'd31); alu = 32'hFFFF0000;
        cyc();
        ctrl = mk(1,0,LS_W,0,WB_MEM,1,5'd21); alu = 32'h100; req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("wrst valid", req_valid, 0);
        chk("wrst wb", wb104, 0);
        chk("wrst we", we104, 0);
        chk("wrst dst", dst104, 0);
        chk("wrst mis", mis104, 0);
        chk("wrst to", to104, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #4;
        chk("rel valid", req_valid, 1);
        chk("rel ready", ready, 0);
        cyc();
        rsp_valid = 1'b1; rsp_data = 32'h12345678;
        #4;
        chk("late valid", req_valid, 1);
        chk("late ready", ready, 0);
        cyc();
        ctrl = '0; rsp_valid = 1'b0;
        #4;
        chk("post ready", ready, 1);
        chk("post wb", wb104, 0);
        chk("post we", we104, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
